// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 64;
    localparam int unsigned DEF_CNT_W  = 10;
    localparam int unsigned STAT_W     = 16;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_valid
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int i = N - 1; i >= 0; i--) begin
            idx = (32'(ptr) + 32'(i)) % N;
            if (req[W'(idx)]) begin
                winner    = W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the write port of a single-clock FIFO.
// Define FIFO_ARB_STATS_EN to add per-requester saturating beat counters (grant_cnt).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [CNT_W-1:0]           fifo_counter,
    output logic                       fifo_wr_en,
    output logic [DATA_W-1:0]          fifo_buf_in,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0]    grant_cnt
`endif
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned BW  = $clog2(MAX_BURST + 1);

    arb_state_t        state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [IDW-1:0]    winner, acc_id;
    logic              any_valid, space_ok, accept, last_beat;
    logic              fifo_wr_en_q;
    logic [DATA_W-1:0] fifo_buf_in_q, sel_data;
    logic [N_REQ-1:0]  ready;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return IDW'(wrap_inc(32'(id), N_REQ));
    endfunction

    rr_pick #(
        .N(N_REQ)
    ) u_pick (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .winner   (winner),
        .any_valid(any_valid)
    );

    // The in-flight registered write is not yet in fifo_counter, so count it here.
    // Gating with rst_n keeps every requester stalled while reset is held.
    assign space_ok  = rst_n && ((32'(fifo_counter) + 32'(fifo_wr_en_q)) < DEPTH);
    assign last_beat = (32'(burst_cnt_q) + 32'd1) == MAX_BURST;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        ready       = '0;
        accept      = 1'b0;
        acc_id      = grant_id_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    ready[winner] = space_ok;
                    acc_id        = winner;
                    if (space_ok) begin
                        accept      = 1'b1;
                        grant_id_d  = winner;
                        burst_cnt_d = BW'(1);
                        if (MAX_BURST == 1) begin
                            rr_ptr_d = next_id(winner);
                        end else begin
                            state_d = BURST;
                        end
                    end
                end
            end
            BURST: begin
                if (req_valid[grant_id_q]) begin
                    ready[grant_id_q] = space_ok;
                    if (space_ok) begin
                        accept      = 1'b1;
                        burst_cnt_d = burst_cnt_q + BW'(1);
                        if (last_beat) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_id(grant_id_q);
                        end
                    end
                end else begin
                    state_d  = IDLE;
                    rr_ptr_d = next_id(grant_id_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc_id == IDW'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            burst_cnt_q   <= '0;
            fifo_wr_en_q  <= 1'b0;
            fifo_buf_in_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            burst_cnt_q  <= burst_cnt_d;
            fifo_wr_en_q <= accept;
            if (accept) begin
                fifo_buf_in_q <= sel_data;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ*STAT_W-1:0] grant_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept && acc_id == IDW'(i) &&
                    grant_cnt_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}}) begin
                    grant_cnt_q[i*STAT_W +: STAT_W] <= grant_cnt_q[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

    assign req_ready   = ready;
    assign fifo_wr_en  = fifo_wr_en_q;
    assign fifo_buf_in = fifo_buf_in_q;
    assign grant_id    = grant_id_q;
    assign busy        = (state_q == BURST) || fifo_wr_en_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// against a grant-level reference model and a FIFO occupancy model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int CW    = 10;
    localparam int MB    = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [CW-1:0]   fifo_counter = '0;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_buf_in;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    fifo_wr_arbiter #(
        .N_REQ    (N),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .CNT_W    (CW),
        .MAX_BURST(MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_counter(fifo_counter),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_buf_in (fifo_buf_in),
        .grant_id    (grant_id),
        .busy        (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt   (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: owner of the open burst (-1 = none), beats in it, scan start.
    int       owner, beats, ptr, occ, last_acc, wr_seen;
    logic     exp_wr;
    logic [7:0] exp_data;
    int       exp_gid;
    int       n_vec = 0;
    int       n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int ncyc, input logic [N-1:0] v);
        rst_n     = 1'b0;
        req_valid = v;
        #1;
        check("reset_ready", 32'(req_ready), 32'd0);
        repeat (ncyc) @(posedge clk);
        #1;
        owner = -1; beats = 0; ptr = 0; occ = 0;
        exp_wr = 1'b0; exp_data = 8'h00; exp_gid = 0; last_acc = -1;
        check("reset_wr_en", 32'(fifo_wr_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_grant_id", 32'(grant_id), 32'd0);
        check("reset_buf_in", 32'(fifo_buf_in), 32'd0);
`ifdef FIFO_ARB_STATS_EN
        check("reset_grant_cnt", (|grant_cnt) ? 32'd1 : 32'd0, 32'd0);
`endif
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    // One clock: drive inputs, check ready, clock, check registered outputs.
    task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d, input bit rd);
        int          w, acc, o;
        bit          space;
        logic [N-1:0] er;
        req_valid    = v;
        req_data     = d;
        fifo_counter = CW'(occ);
        #2;
        space = (occ + int'(exp_wr)) < DEPTH;
        acc   = -1;
        er    = '0;
        if (owner < 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && v[(ptr + k) % N]) w = (ptr + k) % N;
            end
            if (w >= 0 && space) begin
                er[w] = 1'b1;
                acc   = w;
                if (MB == 1) ptr = (w + 1) % N;
                else begin owner = w; beats = 1; end
            end
        end else if (v[owner]) begin
            if (space) begin
                er[owner] = 1'b1;
                acc       = owner;
                beats++;
                if (beats == MB) begin
                    o = owner; ptr = (o + 1) % N; owner = -1;
                end
            end
        end else begin
            o = owner; ptr = (o + 1) % N; owner = -1;
        end
        check("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        #1;
        occ    = occ + int'(exp_wr) - ((rd && occ > 0) ? 1 : 0);
        exp_wr = (acc >= 0);
        if (acc >= 0) begin
            exp_data = d[acc*DW +: DW];
            exp_gid  = acc;
        end
        check("wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        if (exp_wr) check("buf_in", 32'(fifo_buf_in), 32'(exp_data));
        check("grant_id", 32'(grant_id), 32'(exp_gid));
        check("busy", 32'(busy), (owner >= 0 || exp_wr) ? 32'd1 : 32'd0);
        check("no_overflow", (fifo_wr_en === 1'b1 && occ >= DEPTH) ? 32'd1 : 32'd0, 32'd0);
        if (fifo_wr_en === 1'b1) wr_seen++;
        last_acc = acc;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [N-1:0]    v, prev_v;
        logic [N*DW-1:0] d;
        int              rdp;

        owner = -1; beats = 0; ptr = 0; occ = 0; last_acc = -1; wr_seen = 0;
        exp_wr = 1'b0; exp_data = 8'h00; exp_gid = 0;

        // Single beat from requester 0.
        do_reset(2, '0);
        wr_seen = 0;
        cycle(4'b0001, {24'h0, 8'hFF}, 1'b0);
        repeat (3) cycle(4'b0000, '0, 1'b0);
        check("single_pulses", 32'(wr_seen), 32'd1);

        // All four valid: bursts of four, strict rotation.
        do_reset(1, '0);
        wr_seen = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(4'hF, {4{8'(k)}}, 1'b0);
            check("rr_order", 32'(grant_id), 32'((k / 4) % 4));
        end
        check("rr_16_beats", 32'(wr_seen), 32'd16);
        cycle(4'hF, {4{8'hA5}}, 1'b0);
        check("rr_wrap", 32'(grant_id), 32'd0);

        // Pointer at 3 after a requester-2 burst.
        do_reset(1, '0);
        repeat (4) cycle(4'b0100, {4{8'(8'h30 + occ)}}, 1'b0);
        cycle(4'b0101, {8'h0, 8'h22, 8'h0, 8'h11}, 1'b0);
        check("ptr3_first", 32'(grant_id), 32'd0);
        repeat (3) cycle(4'b0101, {8'h0, 8'h22, 8'h0, 8'h11}, 1'b0);
        cycle(4'b0101, {8'h0, 8'h23, 8'h0, 8'h12}, 1'b0);
        check("ptr3_second", 32'(grant_id), 32'd2);

        // Requester 1 withdraws after two beats.
        do_reset(1, '0);
        cycle(4'b0010, {8'h0, 8'h0, 8'h41, 8'h0}, 1'b0);
        cycle(4'b0010, {8'h0, 8'h0, 8'h42, 8'h0}, 1'b0);
        cycle(4'b0000, '0, 1'b0);
        check("drop_idle_busy", 32'(busy), 32'd0);
        cycle(4'b1011, {8'h77, 8'h0, 8'h66, 8'h55}, 1'b0);
        check("drop_next_grant", 32'(grant_id), 32'd3);

        // Reset in the middle of a burst.
        do_reset(1, '0);
        repeat (2) cycle(4'hF, {4{8'h5A}}, 1'b0);
        do_reset(1, 4'hF);
        cycle(4'b0010, {8'h0, 8'h0, 8'h99, 8'h0}, 1'b0);
        check("post_reset_grant", 32'(grant_id), 32'd1);

        // Fill an empty FIFO from requester 0 with no reads.
        do_reset(1, '0);
        wr_seen = 0;
        for (int k = 0; k < 70; k++) cycle(4'b0001, {24'h0, 8'(k + 1)}, 1'b0);
        check("fill_writes", 32'(wr_seen), 32'd64);
        fifo_counter = CW'(occ);
        #1;
        check("fill_ready_low", 32'(req_ready[0]), 32'd0);

        // Randomized traffic; a requester holds its data until accepted.
        do_reset(1, '0);
        prev_v = '0;
        d      = '0;
        for (int c = 0; c < 3000; c++) begin
            rdp = ((c / 500) % 2 == 1) ? 30 : 80;
            v   = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!(prev_v[i] && v[i] && last_acc != i)) d[i*DW +: DW] = 8'($urandom);
            end
            cycle(v, d, $urandom_range(99) < rdp);
            prev_v = v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
